// File: rtl/signed_divider_seq_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// iteration-counter sizing.
package signed_divider_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Iteration counter must index 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/signed_divider_seq_if.sv
// Start/done request and result bus between the operand registers and the
// divider.
interface signed_divider_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/signed_divider_seq_twos_negate.sv
// Combinational two's-complement negation (invert plus one).
module twos_negate #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ~a_i + WIDTH'(1);

endmodule

// File: rtl/signed_divider_seq.sv
// Multi-cycle restoring divider (quotient + remainder) with start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands; otherwise unsigned divide.
module signed_divider_seq
  import signed_divider_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  signed_divider_seq_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned REM_W = WIDTH + 1;
  localparam int unsigned TRY_W = WIDTH + 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH-1:0]   dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic               ovf_c;
  logic [TRY_W-1:0]   rem_shift, trial;

`ifdef SIGNED_DIV_EN
  logic               q_sign_q, r_sign_q, ovf_q;
  logic [WIDTH-1:0]   dvd_neg, dvs_neg, quo_neg, rem_neg;

  twos_negate #(.WIDTH(WIDTH)) u_neg_dvd (.a_i(dvd_q),             .y_o(dvd_neg));
  twos_negate #(.WIDTH(WIDTH)) u_neg_dvs (.a_i(dvs_q),             .y_o(dvs_neg));
  twos_negate #(.WIDTH(WIDTH)) u_neg_quo (.a_i(quo_q),             .y_o(quo_neg));
  twos_negate #(.WIDTH(WIDTH)) u_neg_rem (.a_i(rem_q[WIDTH-1:0]),  .y_o(rem_neg));

  // Signs and the MIN / -1 condition are taken from the raw latched operands in PREP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == S_PREP) begin
      q_sign_q <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
      r_sign_q <= dvd_q[WIDTH-1];
      ovf_q    <= (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
    end
  end

  assign dvd_mag = dvd_q[WIDTH-1] ? dvd_neg : dvd_q;
  assign dvs_mag = dvs_q[WIDTH-1] ? dvs_neg : dvs_q;
  assign quo_fix = q_sign_q ? quo_neg : quo_q;
  assign rem_fix = (r_sign_q && (rem_q[WIDTH-1:0] != '0)) ? rem_neg : rem_q[WIDTH-1:0];
  assign ovf_c   = ovf_q;
`else
  assign dvd_mag = dvd_q;
  assign dvs_mag = dvs_q;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q[WIDTH-1:0];
  assign ovf_c   = 1'b0;
`endif

  // Restoring step: the extra top bit of the trial difference is the borrow.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - TRY_W'(dvs_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d       = bus.dividend;
          dvs_d       = bus.divisor;
          busy_d      = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          overflow_d  = 1'b0;
          state_d     = S_PREP;
        end
      end
      S_PREP: begin
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else begin
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[TRY_W-1]};
        rem_d = trial[TRY_W-1] ? rem_shift[REM_W-1:0] : trial[REM_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = quo_fix;
        remainder_d = rem_fix;
        overflow_d  = ovf_c;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Scoreboard bench for signed_divider_seq: random and corner operands, an
// arithmetic reference model, decoupled driver and done-monitor.
module tb_signed_divider_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           issue;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_e;

  signed_divider_seq_if #(.WIDTH(W)) bus ();

  signed_divider_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer division with truncation toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.issue = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
`ifdef SIGNED_DIV_EN
      int sa, sb;
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      e.q  = W'(sa / sb);
      e.r  = W'(sa % sb);
      e.ov = (sa == -128) && (sb == -1);
`else
      int ua, ub;
      ua  = int'(a);
      ub  = int'(b);
      e.q = W'(ua / ub);
      e.r = W'(ua % ub);
`endif
      e.lat = W + 3;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient",  32'(bus.quotient),  32'(mon_e.q));
        chk("remainder", 32'(bus.remainder), 32'(mon_e.r));
        chk("div_zero",  32'(bus.div_zero),  32'(mon_e.dz));
        chk("overflow",  32'(bus.overflow),  32'(mon_e.ov));
        chk("latency",   32'(cyc - mon_e.issue), 32'(mon_e.lat));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e = model(a, b);
    e.issue = cyc;
    exp_q.push_back(e);
  endtask

  // inj >= 0 re-pulses start (with junk operands) that many cycles into the op.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    int n;
    issue(a, b);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      bus.start = (n == inj);
      if (n == inj) begin
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_quotient"},  32'(bus.quotient),  32'd0);
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
    chk({tag, "_div_zero"},  32'(bus.div_zero),  32'd0);
    chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int sel;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;

    do_op(8'd100, 8'd7, -1);
    do_op(8'h9C, 8'd7, -1);
    do_op(8'd100, 8'hF9, -1);
    do_op(8'd5, 8'd0, -1);
    do_op(8'h80, 8'hFF, -1);
    do_op(8'hFF, 8'h01, -1);
    do_op(8'h7F, 8'h80, -1);
    do_op(8'd37, 8'd9, 2);

    // Reset in the middle of an operation: dropped, no done.
    issue(8'd77, 8'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("midop_reset");
    void'(exp_q.pop_back());
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", 32'(bus.done), 32'd0);
    do_op(8'd100, 8'd7, -1);

    // Reset while a result is being held.
    do_op(8'hC3, 8'd5, -1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle_reset");
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = '0;
      else if (sel == 1) b = 8'hFF;
      else if (sel == 2) begin a = 8'h80; b = 8'hFF; end
      else if (sel == 3) b = W'($urandom_range(1, 3));
      do_op(a, b, (i % 5 == 0) ? 3 : -1);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
